// File: rtl/l15_resp_stub.sv
// Behavioural L1.5 responder stub: accepts one core request at a time and returns after a fixed latency.
// Loads and ifetch misses read a 16-byte line from a small backing memory, and stores write byte lanes of one word.
module l15_resp_stub #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic          clk_i,
  input  logic          reset_l,
  input  logic          req_val_i,
  input  logic [4:0]    req_rqtype_i,
  input  logic [39:0]   req_addr_i,
  input  logic [2:0]    req_size_i,
  input  logic [63:0]   req_data_i,
  input  logic          req_threadid_i,
  output logic          req_ack_o,
  output logic          rtrn_val_o,
  output logic [3:0]    rtrn_rettype_o,
  output logic [127:0]  rtrn_data_o,
  output logic          rtrn_threadid_o,
  input  logic          rtrn_ack_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (AW > 1) ? AW - 1 : 1;
  localparam int NL = DEPTH / 2;

  localparam logic [4:0] RQ_LOAD   = 5'b00000;
  localparam logic [4:0] RQ_STORE  = 5'b00001;
  localparam logic [4:0] RQ_IMISS  = 5'b10000;
  localparam logic [3:0] RET_LOAD  = 4'h0;
  localparam logic [3:0] RET_IFILL = 4'h1;
  localparam logic [3:0] RET_ST    = 4'h4;
  localparam logic [3:0] RET_ERR   = 4'hF;
  localparam logic [3:0] LAT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [4:0]      rqtype_reg;
  logic            threadid_reg;
  logic [LW-1:0]   line_reg;

  logic            accept;
  logic            rd_en;
  logic [AW-1:0]   req_widx;
  logic [LW-1:0]   req_line;
  logic [LW-1:0]   rd_line;
  logic [1:0]      size_eff;
  logic [2:0]      lo_mask;
  logic [2:0]      offset;
  logic [7:0]      wr_be;
  logic [1:0]      wr_sel;
  logic            addr_unused;

  assign req_widx    = req_addr_i[AW+2:3];
  assign req_line    = LW'(req_widx >> 1);
  assign addr_unused = ^req_addr_i[39:AW+3];

  // Acceptance is masked while reset is held so no ack or write can leak out.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_val_i && reset_l) begin
          accept     = 1'b1;
          cnt_next   = LAT_INIT;
          state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg <= 4'd1) begin
          cnt_next   = 4'd0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rtrn_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line data is captured on the edge that enters RESP, after any earlier store has landed.
  assign rd_en   = (state_next == RESP) && (state_reg != RESP);
  assign rd_line = (state_reg == IDLE) ? req_line : line_reg;

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      rqtype_reg   <= 5'd0;
      threadid_reg <= 1'b0;
      line_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        rqtype_reg   <= req_rqtype_i;
        threadid_reg <= req_threadid_i;
        line_reg     <= req_line;
      end
    end
  end

  always_comb begin
    size_eff = (req_size_i > 3'd3) ? 2'd3 : req_size_i[1:0];
    case (size_eff)
      2'd0:    lo_mask = 3'b000;
      2'd1:    lo_mask = 3'b001;
      2'd2:    lo_mask = 3'b011;
      default: lo_mask = 3'b111;
    endcase
    offset = req_addr_i[2:0] & ~lo_mask;
    for (int b = 0; b < 8; b++) begin
      wr_be[b] = ((3'(b) & ~lo_mask) == offset);
    end
    wr_sel    = 2'b00;
    wr_sel[0] = accept && (req_rqtype_i == RQ_STORE) && !req_widx[0];
    wr_sel[1] = accept && (req_rqtype_i == RQ_STORE) && req_widx[0];
  end

  // Even and odd words live in separate banks so a whole line reads in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [63:0] mem [NL] = '{default: '0};
      logic [63:0] rd_reg;

      always_ff @(posedge clk_i) begin
        if (wr_sel[gi]) begin
          for (int b = 0; b < 8; b++) begin
            if (wr_be[b]) mem[req_line][8*b +: 8] <= req_data_i[8*b +: 8];
          end
        end
        if (rd_en) rd_reg <= mem[rd_line];
      end
    end
  endgenerate

  assign req_ack_o  = accept;
  assign rtrn_val_o = (state_reg == RESP);

  always_comb begin
    rtrn_rettype_o  = 4'h0;
    rtrn_data_o     = '0;
    rtrn_threadid_o = 1'b0;
    if (rtrn_val_o) begin
      rtrn_threadid_o = threadid_reg;
      case (rqtype_reg)
        RQ_LOAD: begin
          rtrn_rettype_o = RET_LOAD;
          rtrn_data_o    = {g_bank[1].rd_reg, g_bank[0].rd_reg};
        end
        RQ_IMISS: begin
          rtrn_rettype_o = RET_IFILL;
          rtrn_data_o    = {g_bank[1].rd_reg, g_bank[0].rd_reg};
        end
        RQ_STORE: rtrn_rettype_o = RET_ST;
        default:  rtrn_rettype_o = RET_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_l15_resp_stub.sv
// Directed bench for l15_resp_stub: the driver queues the expected return packet, a negedge monitor checks it.
module tb_l15_resp_stub;
  localparam int LAT = 4;

  logic         clk_i = 1'b0;
  logic         reset_l = 1'b0;
  logic         req_val_i = 1'b0;
  logic [4:0]   req_rqtype_i = '0;
  logic [39:0]  req_addr_i = '0;
  logic [2:0]   req_size_i = '0;
  logic [63:0]  req_data_i = '0;
  logic         req_threadid_i = 1'b0;
  logic         req_ack_o;
  logic         rtrn_val_o;
  logic [3:0]   rtrn_rettype_o;
  logic [127:0] rtrn_data_o;
  logic         rtrn_threadid_o;
  logic         rtrn_ack_i = 1'b0;

  l15_resp_stub #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .reset_l(reset_l), .req_val_i(req_val_i), .req_rqtype_i(req_rqtype_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_data_i(req_data_i),
    .req_threadid_i(req_threadid_i), .req_ack_o(req_ack_o), .rtrn_val_o(rtrn_val_o),
    .rtrn_rettype_o(rtrn_rettype_o), .rtrn_data_o(rtrn_data_o),
    .rtrn_threadid_o(rtrn_threadid_o), .rtrn_ack_i(rtrn_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]   rt;
    logic [127:0] d;
    logic         tid;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every valid cycle must match the head of the queue; the handshake cycle pops it.
  always @(negedge clk_i) begin
    if (reset_l) begin
      if (rtrn_val_o) begin
        if (exp_q.size() == 0) begin
          cmp("rtrn_unexpected", 128'(rtrn_val_o), 128'd0);
        end else begin
          cmp("rtrn_type", 128'(rtrn_rettype_o), 128'(exp_q[0].rt));
          cmp("rtrn_data", rtrn_data_o, exp_q[0].d);
          cmp("rtrn_tid", 128'(rtrn_threadid_o), 128'(exp_q[0].tid));
          if (rtrn_ack_i) void'(exp_q.pop_front());
        end
      end else begin
        cmp("idle_zero", rtrn_data_o | {123'd0, rtrn_rettype_o, rtrn_threadid_o}, 128'd0);
      end
    end
  end

  task automatic do_req(input logic [4:0] rq, input logic [39:0] addr, input logic [2:0] sz,
                        input logic [63:0] data, input logic tid, input logic [3:0] ert,
                        input logic [127:0] ed, input int hold, input bit keep_val);
    exp_t e;
    int   lat;
    e.rt = ert; e.d = ed; e.tid = tid;
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    req_val_i = 1'b1; req_rqtype_i = rq; req_addr_i = addr;
    req_size_i = sz; req_data_i = data; req_threadid_i = tid;
    @(negedge clk_i);
    cmp("req_ack", 128'(req_ack_o), 128'd1);
    @(posedge clk_i); #1;
    if (!keep_val) req_val_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
      if (!rtrn_val_o) cmp("no_reack_wait", 128'(req_ack_o), 128'd0);
    end while (!rtrn_val_o && lat < 20);
    cmp("latency", 128'(lat), 128'(LAT));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      cmp("no_reack_resp", 128'(req_ack_o), 128'd0);
    end
    @(posedge clk_i); #1;
    rtrn_ack_i = 1'b1; req_val_i = 1'b0;
    @(posedge clk_i); #1;
    rtrn_ack_i = 1'b0;
    $display("[TB] req rq=%b addr=%h size=%0d tid=%0d -> rettype %h data %h", rq, addr, sz, tid, ert, ed);
  endtask

  initial begin
    exp_t e;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset state, with a request already pending on the inputs
    req_val_i = 1'b1;
    #2;
    cmp("reset_ack", 128'(req_ack_o), 128'd0);
    cmp("reset_val", 128'(rtrn_val_o), 128'd0);
    cmp("reset_out", rtrn_data_o | {123'd0, rtrn_rettype_o, rtrn_threadid_o}, 128'd0);
    repeat (3) @(posedge clk_i);
    #1;
    req_val_i = 1'b0;
    reset_l = 1'b1;

    do_req(5'b00001, 40'h10, 3'd3, 64'h1122334455667788, 1'b0, 4'h4, 128'd0, 0, 1'b0);
    do_req(5'b00000, 40'h10, 3'd3, 64'h0, 1'b0, 4'h0,
           {64'h0, 64'h1122334455667788}, 0, 1'b0);
    do_req(5'b00001, 40'h13, 3'd0, 64'h00000000AB000000, 1'b0, 4'h4, 128'd0, 0, 1'b0);
    // Held valid and a delayed return ack: outputs stay stable, no second ack
    do_req(5'b00000, 40'h10, 3'd3, 64'h0, 1'b0, 4'h0,
           {64'h0, 64'h11223344AB667788}, 3, 1'b1);
    do_req(5'b00001, 40'h800, 3'd3, 64'hCAFEBABEDEADBEEF, 1'b0, 4'h4, 128'd0, 0, 1'b0);
    do_req(5'b00000, 40'h0, 3'd3, 64'h0, 1'b0, 4'h0,
           {64'h0, 64'hCAFEBABEDEADBEEF}, 0, 1'b0);
    do_req(5'b00100, 40'h0, 3'd3, 64'hFFFFFFFFFFFFFFFF, 1'b1, 4'hF, 128'd0, 1, 1'b0);
    do_req(5'b00000, 40'h0, 3'd3, 64'h0, 1'b1, 4'h0,
           {64'h0, 64'hCAFEBABEDEADBEEF}, 0, 1'b0);
    do_req(5'b00001, 40'h1A, 3'd1, 64'h00000000BEEF0000, 1'b0, 4'h4, 128'd0, 0, 1'b0);
    do_req(5'b10000, 40'h18, 3'd3, 64'h0, 1'b1, 4'h1,
           {64'h00000000BEEF0000, 64'h11223344AB667788}, 0, 1'b0);
    // Misaligned 4-byte store aligns down to bytes 4..7; size 7 behaves as 8 bytes
    do_req(5'b00001, 40'h2F, 3'd2, 64'h7654321099999999, 1'b0, 4'h4, 128'd0, 0, 1'b0);
    do_req(5'b00001, 40'h20, 3'd7, 64'h0102030405060708, 1'b0, 4'h4, 128'd0, 0, 1'b0);
    do_req(5'b00000, 40'hFFFF_0000_20, 3'd3, 64'h0, 1'b0, 4'h0,
           {64'h7654321000000000, 64'h0102030405060708}, 0, 1'b0);

    // Reset pulse while the request sits in WAIT abandons it
    e.rt = 4'h0; e.d = '0; e.tid = 1'b0;
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    req_val_i = 1'b1; req_rqtype_i = 5'b00000; req_addr_i = 40'h10; req_size_i = 3'd3;
    @(posedge clk_i); #1;
    req_val_i = 1'b0;
    @(posedge clk_i); #1;
    reset_l = 1'b0;
    #1;
    cmp("rst_wait_val", 128'(rtrn_val_o), 128'd0);
    void'(exp_q.pop_back());
    req_val_i = 1'b1;
    @(negedge clk_i);
    cmp("rst_wait_ack", 128'(req_ack_o), 128'd0);
    cmp("rst_wait_out", rtrn_data_o | {123'd0, rtrn_rettype_o, rtrn_threadid_o}, 128'd0);
    @(posedge clk_i); #1;
    req_val_i = 1'b0;
    reset_l = 1'b1;
    repeat (LAT + 4) @(negedge clk_i);
    $display("[TB] reset during WAIT: request abandoned");
    do_req(5'b00000, 40'h10, 3'd3, 64'h0, 1'b1, 4'h0,
           {64'h00000000BEEF0000, 64'h11223344AB667788}, 0, 1'b0);

    repeat (3) @(negedge clk_i);
    cmp("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l15_resp_stub.md
L15_RESP_STUB -- requirements
Module: l15_resp_stub

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 64-bit backing words (power of two, at least 2).
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from request accept to return valid (1..15).
REQ-003 SHALL have port clk_i, input, 1 bit, clock.
REQ-004 SHALL have port reset_l, input, 1 bit, reset (asynchronous, active-low).
REQ-005 SHALL have port req_val_i, input, 1 bit, core request valid.
REQ-006 SHALL have port req_rqtype_i, input, 5 bits, request type: LOAD=5'b00000, STORE=5'b00001, IMISS=5'b10000.
REQ-007 SHALL have port req_addr_i, input, 40 bits, physical byte address.
REQ-008 SHALL have port req_size_i, input, 3 bits, access size: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-009 SHALL have port req_data_i, input, 64 bits, store data (little-endian, byte lanes aligned to the address).
REQ-010 SHALL have port req_threadid_i, input, 1 bit, requesting thread.
REQ-011 SHALL have port req_ack_o, output, 1 bit, request accepted (one-cycle pulse).
REQ-012 SHALL have port rtrn_val_o, output, 1 bit, return packet valid.
REQ-013 SHALL have port rtrn_rettype_o, output, 4 bits, return type: LOAD_RET=4'h0, IFILL_RET=4'h1, ST_ACK=4'h4, ERR_RET=4'hF.
REQ-014 SHALL have port rtrn_data_o, output, 128 bits, return data.
REQ-015 SHALL have port rtrn_threadid_o, output, 1 bit, threadid echoed from the request.
REQ-016 SHALL have port rtrn_ack_i, input, 1 bit, core has consumed the return.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP, one request outstanding at a time.
REQ-018 IDLE with req_val_i=1 SHALL assert req_ack_o for that cycle, latch request fields, load counter with LATENCY-1, and go to WAIT.
REQ-019 req_ack_o SHALL be 0 in WAIT and RESP; a held req_val_i SHALL NOT be accepted until the FSM returns to IDLE.
REQ-020 WAIT SHALL decrement the counter each cycle and go to RESP when the counter is 0, so rtrn_val_o rises exactly LATENCY cycles after the ack cycle.
REQ-021 RESP SHALL hold rtrn_val_o=1 and all rtrn_* outputs stable until rtrn_ack_i=1; that cycle SHALL go to IDLE.
REQ-022 rtrn_ack_i while not in RESP SHALL be ignored.
REQ-023 Word index SHALL be addr[3+log2(DEPTH)-1:3], wrapping modulo DEPTH; address bits above the index SHALL be ignored.
REQ-024 Line index SHALL be the word index with bit 0 cleared. Return data SHALL be {mem[line+1], mem[line]}.
REQ-025 LOAD SHALL return LOAD_RET with the 16-byte line containing the address.
REQ-026 IMISS SHALL return IFILL_RET with the same line data.
REQ-027 STORE SHALL write only bytes [addr[2:0] aligned down to size, +2^size) of the indexed word, with byte-enable lanes taken from req_data_i, in the cycle it is accepted.
REQ-028 STORE SHALL return ST_ACK with rtrn_data_o=0.
REQ-029 A STORE to a misaligned address SHALL align down (addr[2:0] AND NOT(2^size-1)).
REQ-030 req_size_i greater than 3 SHALL be treated as 3.
REQ-031 Load data SHALL be sampled when the FSM enters RESP, so a store accepted earlier is always visible.
REQ-032 Any other rqtype SHALL be acked, SHALL NOT modify memory, and SHALL return ERR_RET with data 0.
REQ-033 rtrn_data_o, rtrn_rettype_o and rtrn_threadid_o SHALL be 0 whenever rtrn_val_o=0.

Reset
REQ-034 reset_l low SHALL asynchronously force IDLE, counter=0, req_ack_o=0, rtrn_val_o=0 and all rtrn_* outputs to 0.
REQ-035 Reset SHALL abandon any in-flight request with no return issued.
REQ-036 Backing memory SHALL be zero-initialised at time 0 and SHALL NOT be cleared by reset.
REQ-037 The first request SHALL be accepted no earlier than the first rising edge after reset_l deasserts.

Verification
REQ-038 Directed scenario: STORE addr 0x10, size 3, data 0x1122334455667788, then LOAD addr 0x10 -> ST_ACK, then LOAD_RET with data[63:0]=0x1122334455667788, data[127:64]=0.
REQ-039 Directed scenario: STORE addr 0x13, size 0, data byte lane 3 = 0xAB, then LOAD 0x10 -> only byte 3 of word 2 changes to 0xAB.
REQ-040 Directed scenario: LATENCY=4, LOAD acked at cycle N -> rtrn_val_o rises at cycle N+4; rtrn_ack_i held low for 3 cycles -> outputs stable, and no new ack for a held req_val_i.
REQ-041 Directed scenario: DEPTH=256, STORE to addr 0x800 -> aliases word 0, so LOAD 0x0 returns the stored data (wrap-around).
REQ-042 Directed scenario: rqtype 5'b00100, threadid 1 -> ERR_RET, data 0, threadid 1, memory unchanged.
REQ-043 Directed scenario: reset_l pulsed low during WAIT -> rtrn_val_o=0 immediately, FSM in IDLE, next request served normally.
